amdc_adc_emulator: RTL and testbench
====================================

Name: amdc_adc_emulator

Overview:
- Responder-side model of the AD4011 ADC serial interface inside the eddy current sensor; lets the eddy current SPI master be exercised in hardware-in-the-loop without a Kaman sensor.
- Watches the master's `cnv` and `sclk` lines and enforces a minimum conversion time.
- Returns two 18-bit words, MSB first, on `miso_x` and `miso_y`. The words are staged by software.
- Sits in a test IP next to the eddy current IP and is clocked by the same 200 MHz AXI clock.

Parameters:
- DATA_W, 18, bits per frame on each MISO line.
- CONV_MIN, 60, minimum number of clk cycles the synchronized `cnv` must stay high for a valid conversion.
- CNT_W, 16, width of the frame counter.

Ports:
- clk  in  1  AXI clock, 200 MHz
- rst_n  in  1  asynchronous active-low reset
- cnv  in  1  conversion strobe from the master; asynchronous to clk
- sclk  in  1  serial clock from the master; asynchronous to clk, idles low
- load  in  1  one-cycle strobe that writes the data_x_in/data_y_in staging registers
- data_x_in  in  DATA_W  next X sample
- data_y_in  in  DATA_W  next Y sample
- clr_err  in  1  clears the sticky error flags
- miso_x  out  1  serial X data, registered
- miso_y  out  1  serial Y data, registered
- busy  out  1  high in the CONV and SHIFT states
- frame_done  out  1  one-cycle pulse after the 18th sclk falling edge
- frame_cnt  out  CNT_W  number of completed frames; wraps at 2^CNT_W
- err_short_cnv  out  1  sticky: `cnv` fell before CONV_MIN
- err_sclk_in_cnv  out  1  sticky: an sclk edge was seen while in CONV

Behaviour:
- Reset: all outputs are 0, the staging and shift registers are 0, and the state is IDLE.
- Synchronizers:
  - `cnv` and `sclk` each pass through two flops, then one delay flop.
  - rise = s & ~d; fall = ~s & d.
  - State, shift register and miso update on the 3rd clk edge after a pin transition.
- Staging: `load` writes both staging registers. A `load` in the same cycle as a cnv rise goes to the NEXT frame; the snapshot uses the old staging value.
- IDLE:
  - miso = 0.
  - sclk edges are ignored.
  - cnv rise → CONV. On entry, copy staging into the shift registers, clear the conversion counter, bit_cnt = 0 and fall_seen = 0.
- CONV:
  - miso = 0.
  - The conversion counter increments every cycle and saturates at CONV_MIN.
  - Any sclk rise or fall sets err_sclk_in_cnv.
  - cnv fall with counter ≥ CONV_MIN → SHIFT. In that same cycle miso_x/miso_y take the shift-register MSB (bit 17).
  - cnv fall with counter < CONV_MIN → set err_short_cnv and go to IDLE. No data is driven and frame_cnt is unchanged.
- SHIFT:
  - sclk fall: bit_cnt++ and fall_seen = 1.
    - If bit_cnt reaches DATA_W, go to IDLE, miso = 0, pulse frame_done and increment frame_cnt.
  - sclk rise with fall_seen = 1: shift left by one and drive the new MSB.
  - The first rise of the frame does not shift, so the MSB stays valid through the master's first falling-edge sample.
  - Data therefore changes mid-period, half an sclk period away from the master's falling-edge sample point.
  - cnv rise while in SHIFT aborts the frame: no frame_done, frame_cnt unchanged. Then restart exactly as an IDLE cnv rise (snapshot and enter CONV).
- Simultaneous events: rise and fall of one signal cannot occur in the same cycle. A cnv event takes priority over an sclk event in the same cycle.
- Error flags:
  - Set by their events and cleared only by clr_err.
  - If set and clear occur in the same cycle, set wins.
- Reset mid-frame: returns to IDLE immediately (asynchronous). Staging contents are lost.
- Minimum supported sclk half-period is 4 clk cycles. Faster sclk is unsupported and not checked.

Decomposition:
- Shared package `amdc_adc_emu_pkg` holds:
  - the state encoding: IDLE = 2'b00, CONV = 2'b01, SHIFT = 2'b10;
  - the DATA_W and CONV_MIN defaults.
- One sub-module, `amdc_sync_edge`:
  - a 2-flop synchronizer plus delay flop, outputs s/rise/fall;
  - instantiated once for cnv and once for sclk.

Test Plan:
- Nominal frame:
  - Stimulus: load X=18'h2A5C3, Y=18'h15A3C; `cnv` high 64 cycles; 18 sclk periods with a 10-cycle half-period.
  - Response: a model of the master samples 2A5C3/15A3C, frame_done pulses once and frame_cnt = 1.
- Short conversion: `cnv` high 40 cycles → err_short_cnv = 1, miso stays 0, frame_cnt unchanged; clr_err → flag returns to 0.
- Abort: `cnv` rises after 9 bits of a frame → no frame_done; the next full frame returns the staged data and frame_cnt increments by 1.
- Load/cnv collision: load 18'h3FFFF in the same cycle as the synchronized cnv rise → the frame returns the previous staged value (18'h00001); the next frame returns 3FFFF.
- sclk during conversion: 2 sclk pulses while `cnv` is high → err_sclk_in_cnv = 1 and the frame still completes with correct data.
- Wrap and reset:
  - Preset CNT_W = 4, run 17 frames → frame_cnt = 1.
  - Assert rst_n low mid-SHIFT → all outputs are 0 within the same cycle.

Source files
------------

// File: rtl/amdc_adc_emu_pkg.sv
// Shared definitions for the AD4011 responder model used in eddy current HIL tests.
package amdc_adc_emu_pkg;

  localparam int DATA_W_DEF   = 18;
  localparam int CONV_MIN_DEF = 60;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CONV  = 2'b01,
    SHIFT = 2'b10
  } state_e;

endpackage

// File: rtl/amdc_sync_edge.sv
// Two-flop synchronizer for a pin from the master, plus one delay flop for edge detection.
module amdc_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic s,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic dly_q, dly_d;

  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
    dly_d  = sync_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign s    = sync_q;
  assign rise = sync_q & ~dly_q;
  assign fall = ~sync_q & dly_q;

endmodule

// File: rtl/amdc_adc_emulator.sv
// Responder-side AD4011 model: enforces a minimum conversion time and returns two
// software-staged words MSB first on miso_x/miso_y.
module amdc_adc_emulator
  import amdc_adc_emu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int CONV_MIN = CONV_MIN_DEF,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cnv,
  input  logic              sclk,
  input  logic              load,
  input  logic [DATA_W-1:0] data_x_in,
  input  logic [DATA_W-1:0] data_y_in,
  input  logic              clr_err,
  output logic              miso_x,
  output logic              miso_y,
  output logic              busy,
  output logic              frame_done,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              err_short_cnv,
  output logic              err_sclk_in_cnv
);

  localparam int CONV_W = $clog2(CONV_MIN + 1);
  localparam int BIT_W  = $clog2(DATA_W + 1);

  logic cnv_lvl_unused, cnv_rise, cnv_fall;
  logic sclk_lvl_unused, sclk_rise, sclk_fall;

  amdc_sync_edge u_sync_cnv (
    .clk  (clk),
    .rst_n(rst_n),
    .d_in (cnv),
    .s    (cnv_lvl_unused),
    .rise (cnv_rise),
    .fall (cnv_fall)
  );

  amdc_sync_edge u_sync_sclk (
    .clk  (clk),
    .rst_n(rst_n),
    .d_in (sclk),
    .s    (sclk_lvl_unused),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   stage_x_q, stage_x_d, stage_y_q, stage_y_d;
  logic [DATA_W-1:0]   shift_x_q, shift_x_d, shift_y_q, shift_y_d;
  logic [CONV_W-1:0]   conv_cnt_q, conv_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d, bit_cnt_inc;
  logic                fall_seen_q, fall_seen_d;
  logic                miso_x_q, miso_x_d, miso_y_q, miso_y_d;
  logic                busy_q, busy_d, frame_done_q, frame_done_d;
  logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic                err_short_q, err_short_d, err_sclk_q, err_sclk_d;
  logic                start_frame, short_set, sclk_set;

  assign bit_cnt_inc = bit_cnt_q + BIT_W'(1);

  always_comb begin
    state_d      = state_q;
    stage_x_d    = stage_x_q;
    stage_y_d    = stage_y_q;
    shift_x_d    = shift_x_q;
    shift_y_d    = shift_y_q;
    conv_cnt_d   = conv_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    fall_seen_d  = fall_seen_q;
    miso_x_d     = miso_x_q;
    miso_y_d     = miso_y_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    start_frame  = 1'b0;
    short_set    = 1'b0;
    sclk_set     = 1'b0;

    if (load) begin
      stage_x_d = data_x_in;
      stage_y_d = data_y_in;
    end

    // cnv events are checked first in every state so they win over sclk events.
    case (state_q)
      IDLE: begin
        miso_x_d = 1'b0;
        miso_y_d = 1'b0;
        if (cnv_rise) start_frame = 1'b1;
      end
      CONV: begin
        miso_x_d = 1'b0;
        miso_y_d = 1'b0;
        if (cnv_fall) begin
          if (conv_cnt_q >= CONV_W'(CONV_MIN)) begin
            state_d  = SHIFT;
            miso_x_d = shift_x_q[DATA_W-1];
            miso_y_d = shift_y_q[DATA_W-1];
          end else begin
            short_set = 1'b1;
            state_d   = IDLE;
          end
        end else begin
          if (conv_cnt_q < CONV_W'(CONV_MIN)) conv_cnt_d = conv_cnt_q + CONV_W'(1);
          if (sclk_rise || sclk_fall) sclk_set = 1'b1;
        end
      end
      SHIFT: begin
        if (cnv_rise) begin
          start_frame = 1'b1;
        end else if (sclk_fall) begin
          bit_cnt_d   = bit_cnt_inc;
          fall_seen_d = 1'b1;
          if (bit_cnt_inc == BIT_W'(DATA_W)) begin
            state_d      = IDLE;
            miso_x_d     = 1'b0;
            miso_y_d     = 1'b0;
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + CNT_W'(1);
          end
        end else if (sclk_rise && fall_seen_q) begin
          shift_x_d = {shift_x_q[DATA_W-2:0], 1'b0};
          shift_y_d = {shift_y_q[DATA_W-2:0], 1'b0};
          miso_x_d  = shift_x_q[DATA_W-2];
          miso_y_d  = shift_y_q[DATA_W-2];
        end
      end
      default: state_d = IDLE;
    endcase

    // Snapshot reads the old staging value, so a colliding load lands in the next frame.
    if (start_frame) begin
      state_d     = CONV;
      shift_x_d   = stage_x_q;
      shift_y_d   = stage_y_q;
      conv_cnt_d  = '0;
      bit_cnt_d   = '0;
      fall_seen_d = 1'b0;
      miso_x_d    = 1'b0;
      miso_y_d    = 1'b0;
    end

    err_short_d = short_set | (err_short_q & ~clr_err);
    err_sclk_d  = sclk_set | (err_sclk_q & ~clr_err);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      stage_x_q    <= '0;
      stage_y_q    <= '0;
      shift_x_q    <= '0;
      shift_y_q    <= '0;
      conv_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      fall_seen_q  <= 1'b0;
      miso_x_q     <= 1'b0;
      miso_y_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      err_short_q  <= 1'b0;
      err_sclk_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      stage_x_q    <= stage_x_d;
      stage_y_q    <= stage_y_d;
      shift_x_q    <= shift_x_d;
      shift_y_q    <= shift_y_d;
      conv_cnt_q   <= conv_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      fall_seen_q  <= fall_seen_d;
      miso_x_q     <= miso_x_d;
      miso_y_q     <= miso_y_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      err_short_q  <= err_short_d;
      err_sclk_q   <= err_sclk_d;
    end
  end

  assign miso_x          = miso_x_q;
  assign miso_y          = miso_y_q;
  assign busy            = busy_q;
  assign frame_done      = frame_done_q;
  assign frame_cnt       = frame_cnt_q;
  assign err_short_cnv   = err_short_q;
  assign err_sclk_in_cnv = err_sclk_q;

endmodule

// File: tb/tb_amdc_adc_emulator.sv
// Directed bench: a simple master model drives cnv/sclk and samples miso on sclk falling edges.
module tb_amdc_adc_emulator;

  localparam int DATA_W = 18;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cnv = 1'b0;
  logic              sclk = 1'b0;
  logic              load = 1'b0;
  logic [DATA_W-1:0] data_x_in = '0;
  logic [DATA_W-1:0] data_y_in = '0;
  logic              clr_err = 1'b0;
  logic              miso_x, miso_y, busy, frame_done;
  logic [CNT_W-1:0]  frame_cnt;
  logic              err_short_cnv, err_sclk_in_cnv;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int done_cnt  = 0;
  int done_before;

  logic [DATA_W-1:0] rx_x, rx_y;
  logic              miso_at_fall, busy_in_conv;

  amdc_adc_emulator #(.DATA_W(DATA_W), .CONV_MIN(60), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cnv            (cnv),
    .sclk           (sclk),
    .load           (load),
    .data_x_in      (data_x_in),
    .data_y_in      (data_y_in),
    .clr_err        (clr_err),
    .miso_x         (miso_x),
    .miso_y         (miso_y),
    .busy           (busy),
    .frame_done     (frame_done),
    .frame_cnt      (frame_cnt),
    .err_short_cnv  (err_short_cnv),
    .err_sclk_in_cnv(err_sclk_in_cnv)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && frame_done) done_cnt++;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_cnt++;
    if (observed === expected) pass_cnt++;
    else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic loadStage(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
    data_x_in = x;
    data_y_in = y;
    load = 1'b1;
    waitCycles(1);
    load = 1'b0;
  endtask

  task automatic pulseClr();
    clr_err = 1'b1;
    waitCycles(1);
    clr_err = 1'b0;
    waitCycles(1);
  endtask

  // One master transaction. Pin edges on negedge land in the DUT's decision cycle two negedges later.
  task automatic applyStimulus(input int conv_cycles, input int n_bits, input bit sclk_in_conv,
                               input bit collide, input logic [DATA_W-1:0] cx,
                               input logic [DATA_W-1:0] cy, input bit clr_at_fall);
    rx_x = '0;
    rx_y = '0;
    cnv = 1'b1;
    waitCycles(2);
    if (collide) begin
      data_x_in = cx;
      data_y_in = cy;
      load = 1'b1;
      waitCycles(1);
      load = 1'b0;
    end else begin
      waitCycles(1);
    end
    if (sclk_in_conv) begin
      waitCycles(7);
      sclk = 1'b1; waitCycles(5);
      sclk = 1'b0; waitCycles(5);
      sclk = 1'b1; waitCycles(5);
      sclk = 1'b0; waitCycles(conv_cycles - 26);
    end else begin
      waitCycles(conv_cycles - 4);
    end
    busy_in_conv = busy;
    waitCycles(1);
    cnv = 1'b0;
    waitCycles(2);
    if (clr_at_fall) begin
      clr_err = 1'b1;
      waitCycles(1);
      clr_err = 1'b0;
    end else begin
      waitCycles(1);
    end
    waitCycles(4);
    miso_at_fall = miso_x;
    waitCycles(3);
    for (int i = 0; i < n_bits; i++) begin
      sclk = 1'b1;
      waitCycles(10);
      rx_x = {rx_x[DATA_W-2:0], miso_x};
      rx_y = {rx_y[DATA_W-2:0], miso_y};
      sclk = 1'b0;
      waitCycles(10);
    end
    waitCycles(10);
  endtask

  initial begin
    waitCycles(3);
    checkOutput("reset_flags", {26'b0, miso_x, miso_y, busy, frame_done, err_short_cnv, err_sclk_in_cnv}, 32'h0);
    checkOutput("reset_frame_cnt", 32'(frame_cnt), 32'h0);
    rst_n = 1'b1;
    waitCycles(3);

    // Nominal frame
    loadStage(18'h2A5C3, 18'h15A3C);
    done_before = done_cnt;
    applyStimulus(64, 18, 1'b0, 1'b0, '0, '0, 1'b0);
    checkOutput("nom_busy_conv", 32'(busy_in_conv), 32'h1);
    checkOutput("nom_msb_at_fall", 32'(miso_at_fall), 32'h1);
    checkOutput("nom_rx_x", 32'(rx_x), 32'h2A5C3);
    checkOutput("nom_rx_y", 32'(rx_y), 32'h15A3C);
    checkOutput("nom_done", 32'(done_cnt - done_before), 32'h1);
    checkOutput("nom_frame_cnt", 32'(frame_cnt), 32'h1);
    checkOutput("nom_idle", {29'b0, busy, miso_x, miso_y}, 32'h0);
    checkOutput("nom_errs", {30'b0, err_short_cnv, err_sclk_in_cnv}, 32'h0);

    // Short conversion
    done_before = done_cnt;
    applyStimulus(40, 0, 1'b0, 1'b0, '0, '0, 1'b0);
    checkOutput("short_err", 32'(err_short_cnv), 32'h1);
    checkOutput("short_miso", 32'(miso_at_fall), 32'h0);
    checkOutput("short_busy", 32'(busy), 32'h0);
    checkOutput("short_frame_cnt", 32'(frame_cnt), 32'h1);
    checkOutput("short_done", 32'(done_cnt - done_before), 32'h0);
    pulseClr();
    checkOutput("short_clr", 32'(err_short_cnv), 32'h0);

    // Set beats clear in the same cycle
    applyStimulus(40, 0, 1'b0, 1'b0, '0, '0, 1'b1);
    checkOutput("set_wins", 32'(err_short_cnv), 32'h1);
    pulseClr();

    // sclk activity during conversion
    loadStage(18'h0F0F5, 18'h30A0C);
    applyStimulus(64, 18, 1'b1, 1'b0, '0, '0, 1'b0);
    checkOutput("sclkconv_err", 32'(err_sclk_in_cnv), 32'h1);
    checkOutput("sclkconv_short", 32'(err_short_cnv), 32'h0);
    checkOutput("sclkconv_rx_x", 32'(rx_x), 32'h0F0F5);
    checkOutput("sclkconv_rx_y", 32'(rx_y), 32'h30A0C);
    checkOutput("sclkconv_frame_cnt", 32'(frame_cnt), 32'h2);
    pulseClr();
    checkOutput("sclkconv_clr", 32'(err_sclk_in_cnv), 32'h0);

    // Abort after 9 bits, then a full frame restarting from SHIFT
    loadStage(18'h12345, 18'h2ABCD);
    done_before = done_cnt;
    applyStimulus(64, 9, 1'b0, 1'b0, '0, '0, 1'b0);
    checkOutput("abort_partial_x", 32'(rx_x), 32'h00091);
    checkOutput("abort_busy", 32'(busy), 32'h1);
    checkOutput("abort_done", 32'(done_cnt - done_before), 32'h0);
    loadStage(18'h3C3C3, 18'h05A5A);
    applyStimulus(64, 18, 1'b0, 1'b0, '0, '0, 1'b0);
    checkOutput("abort_rx_x", 32'(rx_x), 32'h3C3C3);
    checkOutput("abort_rx_y", 32'(rx_y), 32'h05A5A);
    checkOutput("abort_frame_cnt", 32'(frame_cnt), 32'h3);
    checkOutput("abort_done_next", 32'(done_cnt - done_before), 32'h1);

    // load colliding with the synchronized cnv rise
    loadStage(18'h00001, 18'h00001);
    applyStimulus(64, 18, 1'b0, 1'b1, 18'h3FFFF, 18'h2AAAA, 1'b0);
    checkOutput("collide_old_x", 32'(rx_x), 32'h00001);
    checkOutput("collide_old_y", 32'(rx_y), 32'h00001);
    applyStimulus(64, 18, 1'b0, 1'b0, '0, '0, 1'b0);
    checkOutput("collide_new_x", 32'(rx_x), 32'h3FFFF);
    checkOutput("collide_new_y", 32'(rx_y), 32'h2AAAA);
    checkOutput("collide_frame_cnt", 32'(frame_cnt), 32'h5);

    // Asynchronous reset mid-SHIFT
    applyStimulus(64, 5, 1'b0, 1'b0, '0, '0, 1'b0);
    checkOutput("rst_pre_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_flags", {26'b0, miso_x, miso_y, busy, frame_done, err_short_cnv, err_sclk_in_cnv}, 32'h0);
    checkOutput("rst_async_frame_cnt", 32'(frame_cnt), 32'h0);
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(3);
    applyStimulus(64, 18, 1'b0, 1'b0, '0, '0, 1'b0);
    checkOutput("rst_stage_lost_x", 32'(rx_x), 32'h0);
    checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'h1);

    // 16 more frames: 17 since reset, 4-bit counter wraps to 1
    for (int i = 0; i < 16; i++) begin
      loadStage(18'h00F00 + 18'(i), 18'h3F000 - 18'(i));
      applyStimulus(64, 18, 1'b0, 1'b0, '0, '0, 1'b0);
    end
    checkOutput("wrap_rx_x", 32'(rx_x), 32'h00F0F);
    checkOutput("wrap_rx_y", 32'(rx_y), 32'h3EFF1);
    checkOutput("wrap_frame_cnt", 32'(frame_cnt), 32'h1);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
